// File: rtl/sim_run_if.sv
// Bundle between the run controller and its surroundings: core-facing controls and taps,
// expected values, and the run verdict.
interface sim_run_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 2,
    parameter int CNT_W    = 16
) ();
    logic                     core_reset;
    logic                     fetch_complete;
    logic [XLEN-1:0]          pc;
    logic [NUM_REGS*XLEN-1:0] reg_values;
    logic [NUM_REGS*XLEN-1:0] expected;
    logic [NUM_REGS-1:0]      check_mask;
    logic                     done;
    logic                     pass;
    logic                     timeout;
    logic [NUM_REGS-1:0]      mismatch_mask;
    logic [CNT_W-1:0]         cycle_count;
    logic [XLEN-1:0]          done_pc;

    modport master (
        output core_reset, done, pass, timeout, mismatch_mask, cycle_count, done_pc,
        input  fetch_complete, pc, reg_values, expected, check_mask
    );

    modport slave (
        input  core_reset, done, pass, timeout, mismatch_mask, cycle_count, done_pc,
        output fetch_complete, pc, reg_values, expected, check_mask
    );
endinterface

// File: rtl/sim_run_controller.sv
// Run controller for core-level simulation: holds the core in reset, runs it under a cycle
// timeout, waits a drain window after fetch_complete, then checks register taps.
module sim_run_controller #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 2,
    parameter int RESET_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int DRAIN_CYCLES   = 10,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    sim_run_if.master  bus
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE,
        S_TIMEOUT
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [XLEN-1:0]     done_pc_q, done_pc_d;
    logic [NUM_REGS-1:0] mismatch_q, mismatch_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic                core_reset_q, core_reset_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        done_pc_d     = done_pc_q;
        mismatch_d    = mismatch_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        core_reset_d  = core_reset_q;

        case (state_q)
            S_HOLD: begin
                core_reset_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                    state_d      = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                core_reset_d  = 1'b0;
                cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
                // Completion takes priority over a timeout landing on the same edge.
                if (bus.fetch_complete) begin
                    done_pc_d   = bus.pc;
                    drain_cnt_d = '0;
                    state_d     = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
                end else if (cycle_count_d == TIMEOUT_CNT) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                core_reset_d = 1'b0;
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = S_CHECK;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                core_reset_d = 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    mismatch_d[i] = bus.check_mask[i] &
                                    (bus.reg_values[i*XLEN +: XLEN] != bus.expected[i*XLEN +: XLEN]);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d       = 1'b1;
                pass_d       = (mismatch_q == '0);
                core_reset_d = 1'b1;
            end
            S_TIMEOUT: begin
                done_d       = 1'b1;
                timeout_d    = 1'b1;
                pass_d       = 1'b0;
                mismatch_d   = '0;
                core_reset_d = 1'b1;
            end
            default: state_d = S_HOLD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
            done_pc_q     <= '0;
            mismatch_q    <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            core_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_pc_q     <= done_pc_d;
            mismatch_q    <= mismatch_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            core_reset_q  <= core_reset_d;
        end
    end

    assign bus.core_reset    = core_reset_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.mismatch_mask = mismatch_q;
    assign bus.cycle_count   = cycle_count_q;
    assign bus.done_pc       = done_pc_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset hold, completion, mismatch, timeout,
// completion/timeout tie, reset mid-drain, and a zero-drain instance.
module tb_sim_run_controller;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sim_run_if #(.XLEN(32), .NUM_REGS(2), .CNT_W(16)) bus0 ();
    sim_run_if #(.XLEN(32), .NUM_REGS(2), .CNT_W(16)) bus1 ();

    sim_run_controller #(
        .XLEN(32), .NUM_REGS(2), .RESET_CYCLES(10), .TIMEOUT_CYCLES(100),
        .DRAIN_CYCLES(10), .CNT_W(16)
    ) dut0 (.clk(clk), .reset(rst0), .bus(bus0.master));

    sim_run_controller #(
        .XLEN(32), .NUM_REGS(2), .RESET_CYCLES(3), .TIMEOUT_CYCLES(100),
        .DRAIN_CYCLES(0), .CNT_W(16)
    ) dut1 (.clk(clk), .reset(rst1), .bus(bus1.master));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals0(input string tag);
        check({tag, "_core_reset"}, 64'(bus0.core_reset), 64'(1));
        check({tag, "_done"},       64'(bus0.done), 64'(0));
        check({tag, "_pass"},       64'(bus0.pass), 64'(0));
        check({tag, "_timeout"},    64'(bus0.timeout), 64'(0));
        check({tag, "_mm"},         64'(bus0.mismatch_mask), 64'(0));
        check({tag, "_cycles"},     64'(bus0.cycle_count), 64'(0));
        check({tag, "_done_pc"},    64'(bus0.done_pc), 64'(0));
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        bus0.fetch_complete = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    // Called on the negedge where reset was released: core_reset high for exactly 10 edges.
    task automatic hold_phase0(input string tag);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 9) check({tag, "_hold_cr_e9"}, 64'(bus0.core_reset), 64'(1));
        end
        check({tag, "_hold_cr_e10"}, 64'(bus0.core_reset), 64'(0));
        check({tag, "_hold_done"},   64'(bus0.done), 64'(0));
    endtask

    task automatic run0(input string tag, input int fetch_at, input logic [63:0] rv,
                        input logic [63:0] ex, input logic [1:0] msk,
                        input logic exp_pass, input logic [1:0] exp_mm);
        reset0();
        check_reset_vals0({tag, "_rst"});
        hold_phase0(tag);
        bus0.reg_values = rv;
        bus0.expected   = ex;
        bus0.check_mask = msk;
        bus0.pc         = 32'h1234_0000;
        for (int e = 1; e < fetch_at; e++) @(negedge clk);
        bus0.pc             = 32'h40;
        bus0.fetch_complete = 1'b1;
        @(negedge clk);
        bus0.fetch_complete = 1'b0;
        bus0.pc             = 32'hdead_beef;
        for (int e = 1; e <= 11; e++) @(negedge clk);
        check({tag, "_done_e11"}, 64'(bus0.done), 64'(0));
        @(negedge clk);
        check({tag, "_done_e12"}, 64'(bus0.done), 64'(1));
        check({tag, "_pass"},     64'(bus0.pass), 64'(exp_pass));
        check({tag, "_mm"},       64'(bus0.mismatch_mask), 64'(exp_mm));
        check({tag, "_done_pc"},  64'(bus0.done_pc), 64'h40);
        check({tag, "_cycles"},   64'(bus0.cycle_count), 64'(fetch_at));
        check({tag, "_core_rst"}, 64'(bus0.core_reset), 64'(1));
        check({tag, "_timeout"},  64'(bus0.timeout), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        bus0.fetch_complete = 1'b0;
        bus0.pc = '0;
        bus0.reg_values = '0;
        bus0.expected = '0;
        bus0.check_mask = '0;
        bus1.fetch_complete = 1'b0;
        bus1.pc = '0;
        bus1.reg_values = '0;
        bus1.expected = '0;
        bus1.check_mask = '0;

        // Taps packed {tap1, tap0}.
        run0("pass",    20,  {32'd7, 32'd5}, {32'd7, 32'd5}, 2'b11, 1'b1, 2'b00);
        run0("miss",    20,  {32'd7, 32'd5}, {32'd8, 32'd5}, 2'b11, 1'b0, 2'b10);
        run0("masked",  20,  {32'd7, 32'd5}, {32'd8, 32'd5}, 2'b01, 1'b1, 2'b00);
        run0("nomask",  7,   {32'hffff_ffff, 32'd0}, {32'd0, 32'd1}, 2'b00, 1'b1, 2'b00);
        run0("tie",     100, {32'd7, 32'd5}, {32'd7, 32'd5}, 2'b11, 1'b1, 2'b00);

        // Timeout with fetch_complete never asserted.
        reset0();
        hold_phase0("to");
        for (int e = 1; e <= 99; e++) @(negedge clk);
        check("to_cycles99",  64'(bus0.cycle_count), 64'(99));
        check("to_done99",    64'(bus0.done), 64'(0));
        k = 0;
        while (bus0.done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("to_reached",   64'(bus0.done), 64'(1));
        check("to_timeout",   64'(bus0.timeout), 64'(1));
        check("to_pass",      64'(bus0.pass), 64'(0));
        check("to_cycles",    64'(bus0.cycle_count), 64'(100));
        check("to_core_rst",  64'(bus0.core_reset), 64'(1));
        check("to_mm",        64'(bus0.mismatch_mask), 64'(0));
        for (int e = 0; e < 5; e++) @(negedge clk);
        check("to_sticky_done",    64'(bus0.done), 64'(1));
        check("to_sticky_timeout", 64'(bus0.timeout), 64'(1));
        check("to_sticky_cycles",  64'(bus0.cycle_count), 64'(100));

        // Reset in the middle of the drain window, then a fresh hold sequence.
        reset0();
        hold_phase0("mid");
        bus0.reg_values = {32'd7, 32'd5};
        bus0.expected   = {32'd7, 32'd5};
        bus0.check_mask = 2'b11;
        for (int e = 1; e < 5; e++) @(negedge clk);
        bus0.pc             = 32'h40;
        bus0.fetch_complete = 1'b1;
        @(negedge clk);
        bus0.fetch_complete = 1'b0;
        check("mid_pc_captured", 64'(bus0.done_pc), 64'h40);
        for (int e = 0; e < 3; e++) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check_reset_vals0("mid_rst");
        rst0 = 1'b0;
        hold_phase0("mid_again");
        check("mid_again_cycles", 64'(bus0.cycle_count), 64'(0));

        // Zero drain window: done two edges after fetch_complete.
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        for (int e = 0; e < 3; e++) @(negedge clk);
        check("d0_core_rst_run", 64'(bus1.core_reset), 64'(0));
        bus1.reg_values = {32'd2, 32'd1};
        bus1.expected   = {32'd3, 32'd1};
        bus1.check_mask = 2'b11;
        @(negedge clk);
        bus1.pc             = 32'h80;
        bus1.fetch_complete = 1'b1;
        @(negedge clk);
        bus1.fetch_complete = 1'b0;
        @(negedge clk);
        check("d0_done_e1",  64'(bus1.done), 64'(0));
        @(negedge clk);
        check("d0_done_e2",  64'(bus1.done), 64'(1));
        check("d0_pass",     64'(bus1.pass), 64'(0));
        check("d0_mm",       64'(bus1.mismatch_mask), 64'(2'b10));
        check("d0_done_pc",  64'(bus1.done_pc), 64'h80);
        check("d0_cycles",   64'(bus1.cycle_count), 64'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
